// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by uart_rx and the companion uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OSR       = 16;
  localparam int MID_START = 7;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: one tick every div+1 clocks.
// Holds at zero while disabled or cleared.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && !clr && (cnt == div);

  // Free-running divider, wraps at div.
  always_ff @(posedge clk) begin
    if (rst || !en || clr) begin
      cnt <= '0;
    end else if (cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled.
// Single-entry holding register with sticky error flags.
module uart_rx #(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx,
  input  logic             rd,
  input  logic             clr_err,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  import uart_pkg::*;

  localparam logic [3:0] LAST_TK = 4'(OSR - 1);
  localparam logic [3:0] MID_TK  = 4'(MID_START);
  localparam logic [2:0] LAST_BT = 3'(DATA_BITS - 1);

  uart_state_e state;
  uart_state_e state_n;

  logic       rx_meta;
  logic       rx_s;
  logic       tick;
  logic [3:0] ostick;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       mid_hit;
  logic       end_hit;
  logic       start_ok;
  logic       bit_smp;
  logic       stop_smp;

  assign busy     = (state != IDLE);
  assign mid_hit  = tick && (ostick == MID_TK);
  assign end_hit  = tick && (ostick == LAST_TK);
  assign start_ok = en && (state == START)
                    && mid_hit && !rx_s;
  assign bit_smp  = en && (state == DATA) && end_hit;
  assign stop_smp = en && (state == STOP) && end_hit;

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (state == IDLE),
    .div (baud_div),
    .tick(tick)
  );

  // Two-flop synchronizer, idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; dropping en aborts the frame.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (mid_hit) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (end_hit && bit_idx == LAST_BT) begin
          state_n = STOP;
        end
      end
      STOP: begin
        if (end_hit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!en) state_n = IDLE;
  end

  // Oversample counter and bit shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ostick  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == IDLE || start_ok) begin
      ostick  <= '0;
      bit_idx <= '0;
    end else if (tick) begin
      ostick <= ostick + 4'd1;
      if (bit_smp) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // Holding register and sticky flags; a new
  // event in the same cycle wins over rd/clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rd && rx_valid) rx_valid <= 1'b0;
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (stop_smp) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (!rx_valid || rd) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx.
// Each task drives one scenario and checks inline.
module tb_uart_rx;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] baud_div;
  logic        rx;
  logic        rd;
  logic        clr_err;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int checks;
  int failures;

  uart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .baud_div (baud_div),
    .rx       (rx),
    .rd       (rd),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input int n);
    rx = 1'b0;
    wait_clks(n);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(n);
    end
    rx = stop;
    wait_clks(n);
    rx = 1'b1;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    wait_clks(1);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clks(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    int bad;
    rst = 1'b1; en = 1'b1; baud_div = 16'd0;
    rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(1);
    got = {rx_data, rx_valid, frame_err, overrun, busy};
    checks++;
    if (got !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got=%h exp=000", got);
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      wait_clks(1);
      if (busy !== 1'b0 || rx_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_200 bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_single_byte();
    int lat;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        while (!rx_valid && lat < 400) begin
          wait_clks(1);
          lat++;
        end
      end
    join
    checks++;
    if (lat != 155) begin
      failures++;
      $display("FAIL byte_latency got=%0d exp=155", lat);
    end
    checks++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL byte_a5 got=%h v=%b exp=a5 v=1",
               rx_data, rx_valid);
    end
    pulse_rd();
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_clear got=%b exp=0", rx_valid);
    end
    wait_clks(10);
  endtask

  task automatic test_glitch();
    int n;
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy got=%b exp=1", busy);
    end
    n = 0;
    while (busy && n < 30) begin
      wait_clks(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || n > 10) begin
      failures++;
      $display("FAIL glitch_reject busy=%b n=%0d exp 0 <=10",
               busy, n);
    end
    wait_clks(20);
    checks++;
    if ({rx_valid, frame_err, overrun} !== 3'b000) begin
      failures++;
      $display("FAIL glitch_flags got=%b exp=000",
               {rx_valid, frame_err, overrun});
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 16);
    wait_clks(20);
    checks++;
    if ({frame_err, rx_valid, overrun} !== 3'b100) begin
      failures++;
      $display("FAIL frame_err got=%b exp=100",
               {frame_err, rx_valid, overrun});
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL clr_err got=%b exp=0", frame_err);
    end
    wait_clks(10);
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    wait_clks(5);
    checks++;
    if (rx_data !== 8'h11 || overrun !== 1'b1
        || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun d=%h ov=%b v=%b exp 11 1 1",
               rx_data, overrun, rx_valid);
    end
    pulse_clr();
    pulse_rd();
    checks++;
    if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear ov=%b v=%b exp 0 0",
               overrun, rx_valid);
    end
    wait_clks(10);
  endtask

  task automatic test_rd_on_load();
    send_frame(8'h11, 1'b1, 16);
    fork
      send_frame(8'h22, 1'b1, 16);
      begin
        wait_clks(154);
        rd = 1'b1;
        wait_clks(1);
        rd = 1'b0;
      end
    join
    wait_clks(5);
    checks++;
    if (rx_data !== 8'h22 || rx_valid !== 1'b1
        || overrun !== 1'b0) begin
      failures++;
      $display("FAIL rd_on_load d=%h v=%b ov=%b exp 22 1 0",
               rx_data, rx_valid, overrun);
    end
    pulse_rd();
    wait_clks(10);
  endtask

  task automatic test_baud_div();
    baud_div = 16'd3;
    wait_clks(5);
    send_frame(8'h5A, 1'b1, 64);
    wait_clks(5);
    checks++;
    if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL baud_div3 d=%h v=%b exp 5a 1",
               rx_data, rx_valid);
    end
  endtask

  task automatic test_en_abort();
    logic b_before;
    logic b_after;
    b_before = 1'b0;
    b_after = 1'b1;
    fork
      send_frame(8'hC3, 1'b1, 64);
      begin
        wait_clks(279);
        b_before = busy;
        en = 1'b0;
        wait_clks(1);
        b_after = busy;
      end
    join
    checks++;
    if (b_before !== 1'b1 || b_after !== 1'b0) begin
      failures++;
      $display("FAIL en_abort before=%b after=%b exp 1 0",
               b_before, b_after);
    end
    en = 1'b1;
    wait_clks(20);
    checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy}
        !== 12'h5A8) begin
      failures++;
      $display("FAIL en_hold d=%h v=%b fe=%b ov=%b bz=%b",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
    baud_div = 16'd0;
  endtask

  task automatic test_reset_mid_frame();
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        wait_clks(80);
        rst = 1'b1;
      end
    join
    wait_clks(2);
    rst = 1'b0;
    wait_clks(30);
    checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy}
        !== 12'h000) begin
      failures++;
      $display("FAIL rst_mid d=%h v=%b fe=%b ov=%b bz=%b",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_rd_on_load();
    test_baud_div();
    test_en_abort();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Consumes the rx signal that the peripheral pin mux routes from the selected porta pin.
- Oversamples rx at 16x the baud rate and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB-first and checks the stop bit.
- Presents each byte in a single-entry holding register with valid, framing-error and overrun flags for the CPU-side register block.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- OSR, 16, oversample ticks per bit; fixed at 16, and the mid-bit sample is at tick 7.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en  input  1  receiver enable
- baud_div  input  DIV_W  a sample tick fires every baud_div+1 clk cycles
- rx  input  1  serial input from the pin mux; asynchronous, idle high
- rd  input  1  one-cycle pulse: CPU has consumed rx_data
- clr_err  input  1  one-cycle pulse: clear frame_err and overrun
- rx_data  output  8  received byte (holding register)
- rx_valid  output  1  holding register full
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte completed while rx_valid=1
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0. Synchronizer flops reset to 1. FSM goes to IDLE and the divider and tick counters clear.
- Reset mid-frame abandons the frame. No flag is set.
- rx passes through a 2-flop synchronizer (rx_s); rx_s is 2 clk behind the pin.
- Tick generator:
  - Counter runs 0..baud_div; tick=1 on the cycle it wraps.
  - baud_div=0 gives a tick every clk.
  - When en=0, counter holds at 0 and there are no ticks.
- FSM states: IDLE, START, DATA, STOP. All transitions are evaluated on tick cycles only, except IDLE entry detection.
  - IDLE: rx_s==0 (sampled on any clk with en=1) -> START. Clear the ostick counter and the tick divider.
  - START: at ostick==7, if rx_s==0 -> DATA with ostick cleared and bit index 0. Otherwise (glitch) -> IDLE with no flags.
  - DATA: at ostick==15, shift rx_s into bit[index], LSB first. After index 7 -> STOP with ostick cleared.
  - STOP: at ostick==15 (mid stop bit), sample rx_s, then:
    - rx_s==1 and (rx_valid==0 or rd this cycle): load rx_data, set rx_valid.
    - rx_s==1 and rx_valid==1 and no rd: set overrun, drop the new byte, keep the old byte.
    - rx_s==0: set frame_err, discard the byte, rx_valid unchanged.
    - In all three cases go to IDLE. The next falling edge can start a new frame immediately (back-to-back frames).
- rx_valid/rx_data update on the clk edge following the stop-sample tick.
- rd with rx_valid=1 clears rx_valid next cycle. rd with rx_valid=0 is ignored.
- rd coinciding with a stop-bit load: new byte loaded, rx_valid stays 1, no overrun.
- clr_err coinciding with a new error: the new error wins and the flag stays 1.
- en falling mid-frame: FSM -> IDLE next cycle, frame dropped. Holding register and flags are retained.
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - state encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - OSR=16 and MID_START=7
  - DATA_BITS=8
  - the same constants are used by the future uart_tx
- One natural sub-module, uart_baud_gen: divider counter producing tick, with en and a sync-clear input. It is shared with uart_tx.
- The synchronizer, FSM, shifter and holding register stay in uart_rx.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, rx=1, en=1, baud_div=0 -> all outputs 0, busy=0 for 200 cycles.
- Single byte: baud_div=0, send 0xA5 8N1 at 16 clk/bit -> rx_valid=1 and rx_data=0xA5 about 154 clk after the start edge. rd pulse -> rx_valid=0 next cycle.
- Glitch rejection: rx low for 4 clk then high -> busy returns to 0 by the ostick-7 check, no rx_valid, no flags.
- Framing error: send 0x3C with stop bit low -> frame_err=1, rx_valid=0. clr_err -> frame_err=0.
- Overrun and simultaneous rd:
  - Send 0x11 then 0x22 back-to-back without rd -> rx_data=0x11, overrun=1.
  - Repeat with rd asserted exactly on the 0x22 stop-load cycle -> rx_data=0x22, rx_valid=1, overrun=0.
- Baud divisor and en abort:
  - baud_div=3, send 0x5A at 64 clk/bit -> rx_data=0x5A.
  - Drop en during bit 3 of the next frame -> busy=0 next cycle, no flag change, 0x5A still held.
